// File: rtl/srff_bank_driver.sv
// srff_bank_driver
//
// Write-side controller for a bank of WIDTH S/R flip-flops. A target word is
// accepted over a valid/ready handshake. Each bit gets the set or reset
// excitation it needs to move from the bank's current state to the target.
// That excitation is pulsed for one clock. The block then waits SETTLE_CYC
// cycles and compares the bank readback against the target. On a mismatch
// it re-drives, up to MAX_RETRY extra times. Every transaction ends with
// exactly one done pulse or one err pulse.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-high
//   tgt_valid  target word valid
//   tgt_ready  block can accept a target (IDLE only)
//   tgt_data   target bank contents
//   q_in       readback of the bank q outputs
//   s_out      per-bit set drive to the bank
//   r_out      per-bit reset drive to the bank
//   busy       high in every state other than IDLE
//   done       one-cycle pulse: bank matched the target
//   err        one-cycle pulse: retries exhausted, bank still mismatched
//   retry_cnt  retries used in the current or last transaction
module srff_bank_driver #(
  parameter int WIDTH      = 8,
  parameter int SETTLE_CYC = 2,
  parameter int MAX_RETRY  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [3:0]       retry_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

  state_t           state;
  logic [WIDTH-1:0] tgt_q;
  logic [3:0]       settle_cnt;

  // Set only bits that must rise and reset only bits that must fall. Bits
  // already at their target get S=R=0, so S=R=1 can never be produced.
  function automatic logic [WIDTH-1:0] set_drive(input logic [WIDTH-1:0] tgt,
                                                 input logic [WIDTH-1:0] q);
    return tgt & ~q;
  endfunction

  function automatic logic [WIDTH-1:0] reset_drive(input logic [WIDTH-1:0] tgt,
                                                   input logic [WIDTH-1:0] q);
    return ~tgt & q;
  endfunction

  assign tgt_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      s_out      <= '0;
      r_out      <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      retry_cnt  <= '0;
      tgt_q      <= '0;
      settle_cnt <= '0;
    end else begin
      // done/err are single-cycle pulses and default low every cycle
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (tgt_valid) begin
            tgt_q     <= tgt_data;
            retry_cnt <= '0;
            s_out     <= set_drive(tgt_data, q_in);
            r_out     <= reset_drive(tgt_data, q_in);
            state     <= DRIVE;
          end
        end
        DRIVE: begin
          s_out      <= '0;
          r_out      <= '0;
          settle_cnt <= '0;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= CHECK;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        CHECK: begin
          // An X/Z readback bit makes the equality unknown, so the test
          // fails and the bank is treated as mismatched.
          if (q_in == tgt_q) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if (retry_cnt < RETRY_LIMIT) begin
            retry_cnt <= retry_cnt + 4'd1;
            s_out     <= set_drive(tgt_q, q_in);
            r_out     <= reset_drive(tgt_q, q_in);
            state     <= DRIVE;
          end else begin
            err   <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_srff_bank_driver.sv
// Testbench for srff_bank_driver. A behavioural S/R bank model feeds q_in.
// The model supports stuck-at-0 bits and can ignore the first set pulse on
// bit 0. Expected done/err pulses are queued when a target is accepted and
// are checked as they appear.
module tb_srff_bank_driver;

  localparam int W   = 8;
  localparam int SC  = 2;
  localparam int MR  = 3;
  localparam int LAT = 2 + SC;

  logic         clk = 1'b0;
  logic         rst;
  logic         tgt_valid;
  logic         tgt_ready;
  logic [W-1:0] tgt_data;
  logic [W-1:0] q_in;
  logic [W-1:0] s_out;
  logic [W-1:0] r_out;
  logic         busy;
  logic         done;
  logic         err;
  logic [3:0]   retry_cnt;

  srff_bank_driver #(.WIDTH(W), .SETTLE_CYC(SC), .MAX_RETRY(MR)) dut (
    .clk       (clk),
    .rst       (rst),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .tgt_data  (tgt_data),
    .q_in      (q_in),
    .s_out     (s_out),
    .r_out     (r_out),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .retry_cnt (retry_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q0;
    logic [W-1:0] tgt;
    logic [W-1:0] stuck;
    logic [W-1:0] s;
    logic [W-1:0] r;
    logic [W-1:0] bank;
    bit           ign;
    bit           is_err;
    logic [3:0]   retry;
    int           pulses;
  } vec_t;

  typedef struct {
    bit         is_err;
    logic [3:0] retry;
    int         cyc;
  } exp_t;

  vec_t         vecs[6];
  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;
  int           pulses = 0;
  logic [W-1:0] bank   = '0;
  logic [W-1:0] stuck0 = '0;
  bit           ign0   = 1'b0;

  assign q_in = bank;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: wait for the falling edge, check outputs, then advance the bank.
  task automatic step();
    exp_t         e;
    logic [W-1:0] s_eff;
    @(negedge clk);
    cyc++;
    chk("s_and_r_zero", 32'(s_out & r_out), 32'h0);
    chk("done_err_excl", 32'(done & err), 32'h0);
    if ((s_out | r_out) != '0) begin
      chk("drive_only_busy", 32'(busy), 32'h1);
      pulses++;
    end
    if (done || err) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse done=%0b err=%0b required none (cycle %0d)", done, err, cyc);
      end else begin
        e = sb.pop_front();
        chk("pulse_is_err", 32'(err), 32'(e.is_err));
        chk("pulse_retry", 32'(retry_cnt), 32'(e.retry));
        chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    s_eff = s_out;
    if (ign0 && s_out[0]) begin
      s_eff[0] = 1'b0;
      ign0     = 1'b0;
    end
    bank = (bank | s_eff) & ~r_out & ~stuck0;
  endtask

  // Queue the expected outcome for an accept at the next rising edge.
  task automatic push_exp(input bit is_err, input logic [3:0] retry);
    exp_t e;
    e.is_err = is_err;
    e.retry  = retry;
    e.cyc    = cyc + 1 + LAT * (1 + int'(retry));
    sb.push_back(e);
  endtask

  task automatic wait_empty(input string name, input int max_cyc);
    for (int k = 0; k < max_cyc && sb.size() != 0; k++) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout actual=pending required=pulse (cycle %0d)", name, cyc);
      sb.delete();
    end
  endtask

  initial begin
    //            q0     tgt    stuck  s      r      bank   ign   err   retry pulses
    vecs[0] = '{8'h0F, 8'hF0, 8'h00, 8'hF0, 8'h0F, 8'hF0, 1'b0, 1'b0, 4'd0, 1};
    vecs[1] = '{8'h5A, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h5A, 1'b0, 1'b0, 4'd0, 0};
    vecs[2] = '{8'h00, 8'h08, 8'h08, 8'h08, 8'h00, 8'h00, 1'b0, 1'b1, 4'd3, 4};
    vecs[3] = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 1'b1, 1'b0, 4'd1, 2};
    vecs[4] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0, 4'd0, 1};
    vecs[5] = '{8'h3C, 8'hA5, 8'h00, 8'h81, 8'h18, 8'hA5, 1'b0, 1'b0, 4'd0, 1};

    rst       = 1'b1;
    tgt_valid = 1'b0;
    tgt_data  = '0;
    step();
    step();
    chk("rst_s_out", 32'(s_out), 32'h0);
    chk("rst_r_out", 32'(r_out), 32'h0);
    chk("rst_ready", 32'(tgt_ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done_err", 32'({done, err}), 32'h0);
    chk("rst_retry", 32'(retry_cnt), 32'h0);
    rst = 1'b0;
    step();

    // Table of single transactions
    for (int i = 0; i < 6; i++) begin
      bank      = vecs[i].q0;
      stuck0    = vecs[i].stuck;
      ign0      = vecs[i].ign;
      pulses    = 0;
      tgt_valid = 1'b1;
      tgt_data  = vecs[i].tgt;
      push_exp(vecs[i].is_err, vecs[i].retry);
      step();
      tgt_valid = 1'b0;
      chk("drive_s_out", 32'(s_out), 32'(vecs[i].s));
      chk("drive_r_out", 32'(r_out), 32'(vecs[i].r));
      chk("drive_busy", 32'(busy), 32'h1);
      wait_empty("vec", 80);
      chk("end_pulses", 32'(pulses), 32'(vecs[i].pulses));
      chk("end_bank", 32'(bank), 32'(vecs[i].bank));
      chk("end_retry", 32'(retry_cnt), 32'(vecs[i].retry));
      chk("end_ready", 32'(tgt_ready), 32'h1);
      step();
      chk("retry_hold", 32'(retry_cnt), 32'(vecs[i].retry));
    end
    stuck0 = '0;
    ign0   = 1'b0;

    // Asynchronous reset in the middle of DRIVE
    bank      = 8'h0F;
    tgt_valid = 1'b1;
    tgt_data  = 8'hF0;
    push_exp(1'b0, 4'd0);
    step();
    tgt_valid = 1'b0;
    chk("abort_drive_s", 32'(s_out), 32'hF0);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    chk("abort_async_s", 32'(s_out), 32'h0);
    chk("abort_async_r", 32'(r_out), 32'h0);
    chk("abort_ready", 32'(tgt_ready), 32'h1);
    chk("abort_done_err", 32'({done, err}), 32'h0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) step();
    chk("abort_quiet_ready", 32'(tgt_ready), 32'h1);

    // tgt_valid held through a busy transaction, then reset during SETTLE
    bank      = 8'h00;
    tgt_valid = 1'b1;
    tgt_data  = 8'h55;
    push_exp(1'b0, 4'd0);
    step();
    tgt_data = 8'hAA;
    chk("hold_first_s", 32'(s_out), 32'h55);
    wait_empty("hold", 20);
    chk("hold_bank", 32'(bank), 32'h55);
    chk("hold_ready_at_done", 32'(tgt_ready), 32'h1);
    push_exp(1'b0, 4'd0);
    step();
    tgt_valid = 1'b0;
    chk("b2b_s", 32'(s_out), 32'hAA);
    chk("b2b_r", 32'(r_out), 32'h55);
    step();
    chk("settle_busy", 32'(busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    chk("settle_abort_ready", 32'(tgt_ready), 32'h1);
    chk("settle_abort_retry", 32'(retry_cnt), 32'h0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) step();
    chk("settle_abort_idle", 32'(busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/srff_bank_driver.md
Name: srff_bank_driver

Overview:
- Write-side controller for a bank of WIDTH S/R flip-flops.
- Accepts a target word over a valid/ready handshake.
- Computes per-bit set/reset excitation from the bank's current state, pulses S/R for one clock, waits for the bank to settle, then reads the bank back.
- Retries on mismatch up to MAX_RETRY times; ends each transaction with exactly one done pulse or one err pulse.

Parameters:
WIDTH, 8, number of flip-flops in the bank
SETTLE_CYC, 2, idle cycles between the S/R pulse and readback compare (legal range 1..15)
MAX_RETRY, 3, extra drive attempts after the first failed compare (legal range 0..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
tgt_valid  input  1  target word valid
tgt_ready  output  1  block can accept a target (high only in IDLE)
tgt_data  input  WIDTH  target bank contents
q_in  input  WIDTH  readback of bank q outputs
s_out  output  WIDTH  set drive to bank, one bit per flip-flop
r_out  output  WIDTH  reset drive to bank, one bit per flip-flop
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse: bank matched target
err  output  1  one-cycle pulse: retries exhausted, bank does not match
retry_cnt  output  4  retries used in the current or last transaction

Behaviour:
- All outputs are registered. busy and tgt_ready are decoded from the registered state.
- Reset (asynchronous, active-high):
  - State goes to IDLE immediately.
  - s_out=0, r_out=0, done=0, err=0, retry_cnt=0, internal target register=0, settle counter=0.
  - Outputs hold those values while rst=1.
  - Reset in any state aborts the transaction. No partial S/R pulse survives and no done/err is emitted.
- FSM states: IDLE, DRIVE, SETTLE, CHECK.
- IDLE:
  - tgt_ready=1, busy=0.
  - When tgt_valid=1 at a clock edge:
    - Latch tgt_data into the target register and clear retry_cnt.
    - Load s_out = tgt_data & ~q_in and r_out = ~tgt_data & q_in.
    - Go to DRIVE.
  - tgt_valid in any other state is ignored (no capture, no queueing).
- DRIVE:
  - Lasts exactly one cycle with s_out/r_out held.
  - Next edge: s_out=r_out=0, settle counter cleared, go to SETTLE.
- SETTLE:
  - s_out=r_out=0.
  - After SETTLE_CYC cycles, go to CHECK.
- CHECK (one cycle), evaluated at its closing edge:
  - If q_in == target register (all bits known and equal): done<=1, go to IDLE.
  - Else if retry_cnt < MAX_RETRY: retry_cnt<=retry_cnt+1, reload s_out/r_out from the target register and the current q_in (same equations as IDLE), go to DRIVE.
  - Else: err<=1, go to IDLE.
  - An X/Z bit on q_in counts as a mismatch.
- done and err:
  - Each is high for exactly one cycle. They are never high together.
  - They coincide with the first IDLE cycle, so tgt_ready=1 in that same cycle and a back-to-back accept is legal there.
- Invariants, checked every cycle:
  - (s_out & r_out) == 0. The illegal S=R=1 combination is never driven.
  - s_out/r_out are nonzero only in DRIVE.
  - Bits where target already equals q_in get S=R=0 (hold).
- Latency:
  - Accept at edge E0, first compare passes: done is high during the cycle after edge E0+2+SETTLE_CYC.
  - With the default SETTLE_CYC=2, that is the cycle after E0+4.
  - Each retry adds 2+SETTLE_CYC cycles.
- Target equal to q_in at accept: still goes DRIVE (all-zero S/R) → SETTLE → CHECK → done, same latency.
- retry_cnt holds its final value after done/err until the next accept.
- Max drive attempts per transaction: 1+MAX_RETRY.

Test Plan:
1. Reset: assert rst mid-cycle while in DRIVE with s_out=0xF0 → s_out=r_out=0x00 with no clock edge; tgt_ready=1; done=err=0; no pulse after rst releases.
2. Basic write, WIDTH=8, SETTLE_CYC=2: q_in=0x0F, accept tgt_data=0xF0, bench bank model updates q_in=0xF0 after the pulse → during DRIVE s_out=0xF0 and r_out=0x0F; done high one cycle, 4 clocks after the accept edge; retry_cnt=0; err=0.
3. No-op write: q_in=0x5A, tgt_data=0x5A → DRIVE shows s_out=r_out=0x00; done after same latency; bank unchanged.
4. Stuck bit: bit 3 of q_in stuck at 0, tgt_data=0x08 from q_in=0x00 → s_out=0x08 pulsed 4 times (1+3 retries); err single pulse; retry_cnt=3; done never asserted.
5. Transient failure: bank ignores the first set pulse on bit 0, tgt_data=0x01 → two DRIVE cycles; done on second CHECK; retry_cnt=1.
6. Busy/abort: hold tgt_valid=1 with data 0xAA throughout a transaction of 0x55 → only 0x55 is captured, 0xAA is taken the cycle done=1; then assert rst during SETTLE → IDLE, no done/err, retry_cnt=0.
